// File: rtl/mem_loop_reducer_pkg.sv
// Shared types for the memory-window reducer: FSM states, reduce modes
// and the per-mode accumulator identity.
package mem_loop_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INIT = 3'd1,
      ST_COND = 3'd2,
      ST_READ = 3'd3,
      ST_WAIT = 3'd4,
      ST_ACC  = 3'd5,
      ST_INCR = 3'd6,
      ST_DONE = 3'd7
   } state_t;

   localparam logic [1:0] MODE_SUM = 2'b00;
   localparam logic [1:0] MODE_MAX = 2'b01;
   localparam logic [1:0] MODE_MIN = 2'b10;
   localparam logic [1:0] MODE_NZ  = 2'b11;

   // min starts from DATA_W ones so the first word always replaces it
   function automatic logic [31:0] mode_identity(input logic [1:0] mode,
                                                 input int unsigned data_w);
      if (mode == MODE_MIN) return {32{1'b1}} >> (32 - data_w);
      return '0;
   endfunction

endpackage

// File: rtl/mem_loop_reducer_alu.sv
// reduce_alu: one reduction step acc (op) d for sum/max/min/count-nonzero.
// SATURATE_EN: when defined, sum clamps at all-ones instead of wrapping.
module reduce_alu
   import mem_loop_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 12
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [DATA_W-1:0] d,
   input  logic [1:0]        mode,
   output logic [ACC_W-1:0]  next_acc,
   output logic              ovf
);

   logic [ACC_W-1:0] dz;
   logic [ACC_W:0]   sum_w;

   assign dz = ACC_W'(d);

   always_comb begin
      sum_w    = {1'b0, acc} + {1'b0, dz};
      next_acc = acc;
      ovf      = 1'b0;
      case (mode)
         MODE_SUM: begin
            ovf = sum_w[ACC_W];
`ifdef SATURATE_EN
            next_acc = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
`else
            next_acc = sum_w[ACC_W-1:0];
`endif
         end
         MODE_MAX: if (dz > acc) next_acc = dz;
         MODE_MIN: if (dz < acc) next_acc = dz;
         MODE_NZ:  if (d != '0) next_acc = acc + ACC_W'(1);
         default:  next_acc = acc;
      endcase
   end

endmodule

// File: rtl/mem_loop_reducer.sv
// Step-enabled FSM walking a wrapping window of a sync-read RAM and reducing
// it via reduce_alu. Optional SATURATE_EN makes sum mode clamp instead of wrap.
module mem_loop_reducer
   import mem_loop_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 5,
   parameter int CNT_W   = 6,
   parameter int ACC_W   = 12,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_en,
   input  logic              go,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output logic [CNT_W-1:0]  index,
   output logic              overflow
);

   localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

   state_t            state;
   logic [ADDR_W-1:0] base_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        mode_r;
   logic [CNT_W-1:0]  idx_r;
   logic [ACC_W-1:0]  acc_r;
   logic              ovf_r;
   logic [1:0]        wait_r;
   logic [ACC_W-1:0]  alu_next;
   logic              alu_ovf;

   reduce_alu #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
   ) u_alu (
      .acc     (acc_r),
      .d       (mem_rdata),
      .mode    (mode_r),
      .next_acc(alu_next),
      .ovf     (alu_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         base_r <= '0;
         cnt_r  <= '0;
         mode_r <= '0;
         idx_r  <= '0;
         acc_r  <= '0;
         ovf_r  <= 1'b0;
         wait_r <= '0;
      end else if (step_en) begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (go) begin
                  base_r <= start_addr;
                  cnt_r  <= count;
                  mode_r <= mode;
                  state  <= ST_INIT;
               end
            end
            ST_INIT: begin
               idx_r <= '0;
               ovf_r <= 1'b0;
               acc_r <= ACC_W'(mode_identity(mode_r, DATA_W));
               state <= ST_COND;
            end
            ST_COND: state <= (idx_r < cnt_r) ? ST_READ : ST_DONE;
            ST_READ: begin
               wait_r <= '0;
               state  <= (MEM_LAT == 1) ? ST_ACC : ST_WAIT;
            end
            // WAIT occupies MEM_LAT-1 steps; wait_r counts them from zero
            ST_WAIT: begin
               if (wait_r == WAIT_LAST) state <= ST_ACC;
               else wait_r <= wait_r + 2'd1;
            end
            ST_ACC: begin
               acc_r <= alu_next;
               if (alu_ovf) ovf_r <= 1'b1;
               state <= ST_INCR;
            end
            ST_INCR: begin
               idx_r <= idx_r + CNT_W'(1);
               state <= ST_COND;
            end
            default: begin
               state  <= ST_IDLE;
               base_r <= '0;
               cnt_r  <= '0;
               mode_r <= '0;
               idx_r  <= '0;
               acc_r  <= '0;
               ovf_r  <= 1'b0;
               wait_r <= '0;
            end
         endcase
      end
   end

   assign mem_addr = base_r + ADDR_W'(idx_r);
   assign busy     = (state != ST_IDLE) && (state != ST_DONE);
   assign done     = (state == ST_DONE);
   assign result   = acc_r;
   assign index    = idx_r;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_mem_loop_reducer.sv
// Bench: two reducer instances (12-bit acc/lat 1, 8-bit acc/lat 2) on one RAM,
// checked each cycle against a window-level arithmetic model.
module tb_mem_loop_reducer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step_en = 1'b1;
   logic       go = 1'b0;
   logic [4:0] start_addr = '0;
   logic [5:0] count = '0;
   logic [1:0] mode = '0;

   logic [4:0]  addr_a, addr_b;
   logic [7:0]  rdata_a = '0, rdata_b = '0;
   logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
   logic [11:0] res_a;
   logic [7:0]  res_b;
   logic [5:0]  idx_a, idx_b;

   logic [7:0] ram [32];
   int total = 0;
   int bad = 0;
   int step_mode = 0;
   int step_ctr = 0;

   int m_phase [2] = '{0, 0};
   int m_n     [2] = '{0, 0};
   int m_total [2] = '{0, 0};
   int m_base  [2] = '{0, 0};
   int m_cnt   [2] = '{0, 0};
   int m_res   [2] = '{0, 0};
   int m_ovf   [2] = '{0, 0};

   always #5 clk = ~clk;

   mem_loop_reducer #(.DATA_W(8), .ADDR_W(5), .CNT_W(6), .ACC_W(12), .MEM_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .step_en(step_en), .go(go), .start_addr(start_addr),
      .count(count), .mode(mode), .mem_addr(addr_a), .mem_rdata(rdata_a),
      .busy(busy_a), .done(done_a), .result(res_a), .index(idx_a), .overflow(ovf_a));

   mem_loop_reducer #(.DATA_W(8), .ADDR_W(5), .CNT_W(6), .ACC_W(8), .MEM_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .step_en(step_en), .go(go), .start_addr(start_addr),
      .count(count), .mode(mode), .mem_addr(addr_b), .mem_rdata(rdata_b),
      .busy(busy_b), .done(done_b), .result(res_b), .index(idx_b), .overflow(ovf_b));

   always @(posedge clk) begin
      if (step_en) begin
         rdata_a <= ram[addr_a];
         rdata_b <= ram[addr_b];
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic int accw_of(input int k);
      return (k == 0) ? 12 : 8;
   endfunction

   // expected result straight from the window contents
   function automatic void model_run(input int accw, input int md, input int ba,
                                     input int cn, output int res, output int ovf);
      int tot = 0, mx = 0, mn = 255, nz = 0, dv, lim;
      for (int j = 0; j < cn; j++) begin
         dv = int'(ram[(ba + j) % 32]);
         tot += dv;
         if (dv > mx) mx = dv;
         if (dv < mn) mn = dv;
         if (dv != 0) nz++;
      end
      lim = (1 << accw) - 1;
      ovf = 0;
      case (md)
         0: begin
`ifdef SATURATE_EN
            res = (tot > lim) ? lim : tot;
`else
            res = tot % (lim + 1);
`endif
            ovf = (tot > lim) ? 1 : 0;
         end
         1: res = mx;
         2: res = mn;
         default: res = nz;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) m_phase[k] <= 0;
      end else if (step_en) begin
         for (int k = 0; k < 2; k++) begin
            int r, o;
            if (m_phase[k] != 1 && go) begin
               model_run(accw_of(k), int'(mode), int'(start_addr), int'(count), r, o);
               m_phase[k] <= 1;
               m_n[k]     <= 1;
               m_base[k]  <= int'(start_addr);
               m_cnt[k]   <= int'(count);
               m_res[k]   <= r;
               m_ovf[k]   <= o;
               m_total[k] <= 3 + int'(count) * (3 + lat_of(k));
            end else if (m_phase[k] == 1) begin
               m_n[k] <= m_n[k] + 1;
               if (m_n[k] + 1 == m_total[k]) m_phase[k] <= 2;
            end
         end
      end
   end

   task automatic check_inst(input int k, input int b, input int d, input int res,
                             input int idx, input int o, input int addr);
      int n, p, j, r;
      string s;
      s = (k == 0) ? "a" : "b";
      case (m_phase[k])
         0: begin
            chk({"idle_busy_", s}, b, 0);
            chk({"idle_done_", s}, d, 0);
            chk({"idle_result_", s}, res, 0);
            chk({"idle_index_", s}, idx, 0);
            chk({"idle_ovf_", s}, o, 0);
            chk({"idle_addr_", s}, addr, 0);
         end
         1: begin
            chk({"run_busy_", s}, b, 1);
            chk({"run_done_", s}, d, 0);
            n = m_n[k];
            p = 3 + lat_of(k);
            if (n == 2) chk({"run_index_", s}, idx, 0);
            if (n >= 3) begin
               j = (n - 3) / p;
               r = (n - 3) % p;
               if (r <= lat_of(k)) begin
                  chk({"run_addr_", s}, addr, (m_base[k] + j) % 32);
                  chk({"run_index_", s}, idx, j);
               end else if (r == lat_of(k) + 1) begin
                  chk({"run_index_", s}, idx, j);
               end else begin
                  chk({"run_index_", s}, idx, j + 1);
               end
            end
         end
         default: begin
            chk({"done_busy_", s}, b, 0);
            chk({"done_done_", s}, d, 1);
            chk({"done_result_", s}, res, m_res[k]);
            chk({"done_ovf_", s}, o, m_ovf[k]);
            chk({"done_index_", s}, idx, m_cnt[k]);
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check_inst(0, int'(busy_a), int'(done_a), int'(res_a), int'(idx_a), int'(ovf_a), int'(addr_a));
         check_inst(1, int'(busy_b), int'(done_b), int'(res_b), int'(idx_b), int'(ovf_b), int'(addr_b));
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         step_ctr++;
         case (step_mode)
            0: step_en = 1'b1;
            1: step_en = (step_ctr % 4 == 0);
            default: step_en = 1'($urandom % 2);
         endcase
      end
   end

   task automatic issue_go(input int md, input int ba, input int cn);
      bit hit = 0;
      mode = 2'(md);
      start_addr = 5'(ba);
      count = 6'(cn);
      go = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         if (step_en) begin
            hit = 1;
            break;
         end
      end
      #2 go = 1'b0;
      if (!hit) chk("go_step_timeout", 0, 1);
   endtask

   task automatic wait_done(input int s0, output int sa, output int sb);
      int s = s0;
      sa = -1;
      sb = -1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         if (step_en) s++;
         #1;
         if (done_a && sa < 0) sa = s;
         if (done_b && sb < 0) sb = s;
         if (sa >= 0 && sb >= 0) break;
      end
      if (sa < 0 || sb < 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int sa, sb, s0;
      bit hit;
      for (int i = 0; i < 32; i++) ram[i] = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_result_a", int'(res_a), 0);
      chk("rst_busy_b", int'(busy_b), 0);

      for (int i = 0; i < 10; i++) ram[i] = 8'(i + 1);
      issue_go(0, 0, 10);
      wait_done(1, sa, sb);
      chk("sum_steps_a", sa, 43);
      chk("sum_steps_b", sb, 53);
      chk("sum_res_a", int'(res_a), 55);
      chk("sum_res_b", int'(res_b), 55);
      chk("sum_ovf_a", int'(ovf_a), 0);
      chk("sum_index_a", int'(idx_a), 10);

      issue_go(1, 0, 10);
      wait_done(1, sa, sb);
      chk("max_res_a", int'(res_a), 10);
      chk("max_index_b", int'(idx_b), 10);
      issue_go(2, 0, 10);
      wait_done(1, sa, sb);
      chk("min_res_a", int'(res_a), 1);
      chk("min_res_b", int'(res_b), 1);

      issue_go(2, 7, 0);
      wait_done(1, sa, sb);
      chk("cnt0_steps_a", sa, 3);
      chk("cnt0_steps_b", sb, 3);
      chk("cnt0_res_a", int'(res_a), 255);
      chk("cnt0_res_b", int'(res_b), 255);

      ram[30] = 8'd5; ram[31] = 8'd0; ram[0] = 8'd1; ram[1] = 8'd2;
      issue_go(3, 30, 4);
      wait_done(1, sa, sb);
      chk("nz_wrap_res_a", int'(res_a), 3);
      chk("nz_wrap_res_b", int'(res_b), 3);

      for (int i = 0; i < 8; i++) ram[i] = 8'hFF;
      issue_go(0, 0, 8);
      wait_done(1, sa, sb);
      chk("ff_sum_res_a", int'(res_a), 2040);
      chk("ff_sum_ovf_a", int'(ovf_a), 0);
`ifdef SATURATE_EN
      chk("ff_sum_res_b", int'(res_b), 255);
`else
      chk("ff_sum_res_b", int'(res_b), 248);
`endif
      chk("ff_sum_ovf_b", int'(ovf_b), 1);

      // slow tick, with go retriggered while busy
      for (int i = 0; i < 10; i++) ram[i] = 8'(i + 1);
      step_mode = 1;
      issue_go(0, 0, 10);
      s0 = 0;
      mode = 2'd2; start_addr = 5'd5; count = 6'd3; go = 1'b1;
      repeat (20) begin
         @(posedge clk);
         if (step_en) s0++;
      end
      #2 go = 1'b0;
      wait_done(1 + s0, sa, sb);
      chk("slow_steps_a", sa, 43);
      chk("slow_steps_b", sb, 53);
      chk("slow_res_a", int'(res_a), 55);
      chk("slow_res_b", int'(res_b), 55);

      issue_go(0, 0, 10);
      hit = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (m_phase[1] == 1 && m_n[1] >= 3 && (m_n[1] - 3) % 5 == 2) begin
            hit = 1;
            break;
         end
      end
      if (!hit) chk("acc_wait_timeout", 0, 1);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_busy_a", int'(busy_a), 0);
      chk("mid_rst_busy_b", int'(busy_b), 0);
      chk("mid_rst_done_b", int'(done_b), 0);
      chk("mid_rst_res_a", int'(res_a), 0);
      chk("mid_rst_res_b", int'(res_b), 0);
      chk("mid_rst_idx_b", int'(idx_b), 0);
      chk("mid_rst_addr_b", int'(addr_b), 0);
      chk("mid_rst_ovf_b", int'(ovf_b), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      step_mode = 0;
      issue_go(0, 0, 10);
      wait_done(1, sa, sb);
      chk("post_rst_res_a", int'(res_a), 55);

      for (int t = 0; t < 30; t++) begin
         step_mode = t % 3;
         for (int i = 0; i < 32; i++)
            ram[i] = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom % 256);
         issue_go(int'($urandom % 4), int'($urandom % 32), int'($urandom_range(0, 20)));
         wait_done(1, sa, sb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
